// File: rtl/icb_split4_if.sv
// ICB bundle: command and response channels for N lanes sharing one broadcast command payload.
// N=1 models a single master port, N=4 the fan-out side of the splitter.
interface icb_split4_if #(
  parameter int N = 1
);
  logic [N-1:0]    cmd_valid;
  logic [N-1:0]    cmd_ready;
  logic [31:0]     cmd_addr;
  logic            cmd_read;
  logic [31:0]     cmd_wdata;
  logic [3:0]      cmd_wmask;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [N-1:0]    rsp_err;
  logic [32*N-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/icb_split4.sv
// 1-to-4 ICB splitter: region decode on addr[31:28], in-order responses via a target-ID FIFO,
// and an internal error slave that completes commands to unmapped regions.
module icb_split4 #(
  parameter logic [3:0] S0_REGION = 4'h1,
  parameter logic [3:0] S1_REGION = 4'h2,
  parameter logic [3:0] S2_REGION = 4'h3,
  parameter logic [3:0] S3_REGION = 4'h4,
  parameter int         OT_DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  icb_split4_if.slave  m_icb,
  icb_split4_if.master s_icb
);

  localparam int PW = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
  localparam int CW = $clog2(OT_DEPTH + 1);
  localparam logic [2:0]    ERR_TGT  = 3'd4;
  localparam logic [CW-1:0] FULL_CNT = CW'(OT_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(OT_DEPTH - 1);

  logic [2:0]    r_fifo [OT_DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_lastTgt;
  logic          r_errValid;

  logic [2:0] w_tgt;
  logic [2:0] w_head;
  logic       w_empty;
  logic       w_block;
  logic       w_tgtReady;
  logic       w_cmdReady;
  logic       w_push;
  logic       w_headIsErr;
  logic       w_rspValid;
  logic       w_pop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_tgt = ERR_TGT;
    if (m_icb.cmd_addr[31:28] == S0_REGION)      w_tgt = 3'd0;
    else if (m_icb.cmd_addr[31:28] == S1_REGION) w_tgt = 3'd1;
    else if (m_icb.cmd_addr[31:28] == S2_REGION) w_tgt = 3'd2;
    else if (m_icb.cmd_addr[31:28] == S3_REGION) w_tgt = 3'd3;
  end

  // Only one target may have commands in flight, so responses can never return out of order.
  assign w_empty     = (r_count == '0);
  assign w_block     = (r_count == FULL_CNT) | (~w_empty & (w_tgt != r_lastTgt));
  assign w_tgtReady  = (w_tgt == ERR_TGT) ? ~r_errValid : s_icb.cmd_ready[w_tgt[1:0]];
  assign w_cmdReady  = rst_n & ~w_block & w_tgtReady;
  assign w_push      = m_icb.cmd_valid[0] & w_cmdReady;

  assign w_head      = r_fifo[r_rdPtr];
  assign w_headIsErr = (w_head == ERR_TGT);
  assign w_rspValid  = rst_n & ~w_empty &
                       (w_headIsErr ? r_errValid : s_icb.rsp_valid[w_head[1:0]]);
  assign w_pop       = w_rspValid & m_icb.rsp_ready[0];

  always_comb begin
    s_icb.cmd_valid = '0;
    s_icb.rsp_ready = '0;
    if (rst_n && !w_block && (w_tgt != ERR_TGT)) begin
      s_icb.cmd_valid[w_tgt[1:0]] = m_icb.cmd_valid[0];
    end
    if (rst_n && !w_empty && !w_headIsErr) begin
      s_icb.rsp_ready[w_head[1:0]] = m_icb.rsp_ready[0];
    end
  end

  // Broadcast payload is forced to zero while reset is held so every output reads 0.
  assign s_icb.cmd_addr  = rst_n ? m_icb.cmd_addr  : '0;
  assign s_icb.cmd_read  = rst_n & m_icb.cmd_read;
  assign s_icb.cmd_wdata = rst_n ? m_icb.cmd_wdata : '0;
  assign s_icb.cmd_wmask = rst_n ? m_icb.cmd_wmask : '0;

  assign m_icb.cmd_ready = w_cmdReady;
  assign m_icb.rsp_valid = w_rspValid;

  always_comb begin
    m_icb.rsp_err   = '0;
    m_icb.rsp_rdata = '0;
    if (w_rspValid) begin
      if (w_headIsErr) begin
        m_icb.rsp_err = 1'b1;
      end else begin
        m_icb.rsp_err   = s_icb.rsp_err[w_head[1:0]];
        m_icb.rsp_rdata = s_icb.rsp_rdata[{w_head[1:0], 5'b0} +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OT_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_lastTgt  <= '0;
      r_errValid <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wrPtr] <= w_tgt;
        r_wrPtr         <= nextPtr(r_wrPtr);
        r_lastTgt       <= w_tgt;
      end
      if (w_pop) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Accepting an error command requires the error slave to be free, so set and clear never collide.
      if (w_push && (w_tgt == ERR_TGT)) begin
        r_errValid <= 1'b1;
      end else if (w_pop && w_headIsErr) begin
        r_errValid <= 1'b0;
      end
    end
  end

  for (genvar n = 0; n < 4; n++) begin : g_rspChk
    a_rspFromHead: assert property (@(posedge clk) disable iff (!rst_n)
      s_icb.rsp_valid[n] |-> (!w_empty && (w_head == 3'(n))));
  end

endmodule

// File: tb/tb_icb_split4.sv
// Randomized bench for icb_split4: slave models, a spec-level ordering model and a response
// scoreboard drained by an independent monitor.
module tb_icb_split4;

  localparam int OT = 2;

  typedef struct {
    int          tgt;
    logic        rd;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icb_split4_if #(.N(1)) mIcb();
  icb_split4_if #(.N(4)) sIcb();

  icb_split4 #(.OT_DEPTH(OT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .m_icb(mIcb),
    .s_icb(sIcb)
  );

  int   checks = 0;
  int   errors = 0;
  bit   abort = 0;
  exp_t expQ[$];

  logic        cmdPending = 0;
  int          cmdWait = 0;
  logic [31:0] curAddr, curWdata;
  logic [3:0]  curMask, lastRgn = 4'h1;
  logic        curRead;

  logic [32:0] slvMem[4][8];
  int          slvWr[4], slvRd[4], slvCnt[4];
  bit          slvPresent[4];

  function automatic int refTarget(input logic [31:0] addr);
    case (addr[31:28])
      4'h1:    return 0;
      4'h2:    return 1;
      4'h3:    return 2;
      4'h4:    return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [32:0] slaveResp(input int n, input logic [31:0] addr);
    logic [31:0] d = addr ^ (32'h1357_9BDF * 32'(n + 1));
    return {addr[3:2] == 2'b11, d};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_m_cmd_ready"}, 64'(mIcb.cmd_ready), 0);
    checkOutput({tag, "_m_rsp_valid"}, 64'(mIcb.rsp_valid), 0);
    checkOutput({tag, "_m_rsp_err"},   64'(mIcb.rsp_err), 0);
    checkOutput({tag, "_m_rsp_rdata"}, 64'(mIcb.rsp_rdata), 0);
    checkOutput({tag, "_s_cmd_valid"}, 64'(sIcb.cmd_valid), 0);
    checkOutput({tag, "_s_rsp_ready"}, 64'(sIcb.rsp_ready), 0);
    checkOutput({tag, "_s_cmd_addr"},  64'(sIcb.cmd_addr), 0);
    checkOutput({tag, "_s_cmd_wdata"}, 64'(sIcb.cmd_wdata), 0);
    checkOutput({tag, "_s_cmd_wmask"}, 64'(sIcb.cmd_wmask), 0);
    checkOutput({tag, "_s_cmd_read"},  64'(sIcb.cmd_read), 0);
  endtask

  task automatic clearModels();
    expQ.delete();
    cmdPending = 0;
    cmdWait = 0;
    for (int n = 0; n < 4; n++) begin
      slvWr[n] = 0;
      slvRd[n] = 0;
      slvCnt[n] = 0;
      slvPresent[n] = 0;
    end
    mIcb.cmd_valid = 1'b0;
    sIcb.rsp_valid = 4'h0;
  endtask

  // Drives a live read to slave 0 with every slave ready, then checks reset forces all outputs low.
  task automatic pulseReset(input string tag);
    mIcb.cmd_valid = 1'b1;
    mIcb.cmd_addr  = 32'h1000_0010;
    mIcb.cmd_read  = 1'b1;
    mIcb.cmd_wdata = 32'hFFFF_FFFF;
    mIcb.cmd_wmask = 4'hF;
    mIcb.rsp_ready = 1'b1;
    sIcb.cmd_ready = 4'hF;
    #1 rst_n = 1'b0;
    #1 checkResetOutputs(tag);
    clearModels();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Compares DUT state against the ordering model, then records this cycle's handshakes.
  task automatic observe();
    int         tgt;
    bit         blocked, hasErr;
    logic       expReady, expRspValid;
    logic [3:0] expVec, expRspRdy;
    exp_t       e;
    logic [32:0] r;

    hasErr = 0;
    foreach (expQ[i]) if (expQ[i].tgt == 4) hasErr = 1;
    expRspValid = 1'b0;
    expRspRdy   = 4'h0;
    if (expQ.size() != 0) begin
      if (expQ[0].tgt == 4) begin
        expRspValid = 1'b1;
      end else begin
        expRspValid = sIcb.rsp_valid[expQ[0].tgt];
        expRspRdy[expQ[0].tgt] = mIcb.rsp_ready[0];
      end
    end
    checkOutput("m_rsp_valid", 64'(mIcb.rsp_valid), 64'(expRspValid));
    checkOutput("s_rsp_ready", 64'(sIcb.rsp_ready), 64'(expRspRdy));

    if (cmdPending) begin
      tgt = refTarget(curAddr);
      blocked = (expQ.size() == OT) ||
                (expQ.size() != 0 && expQ[expQ.size() - 1].tgt != tgt);
      expReady = !blocked && ((tgt == 4) ? !hasErr : sIcb.cmd_ready[tgt]);
      expVec = (!blocked && tgt < 4) ? 4'(1 << tgt) : 4'h0;
      checkOutput("m_cmd_ready", 64'(mIcb.cmd_ready), 64'(expReady));
      checkOutput("s_cmd_valid", 64'(sIcb.cmd_valid), 64'(expVec));
      if (mIcb.cmd_ready[0]) begin
        if (tgt < 4) begin
          checkOutput("s_cmd_addr",  64'(sIcb.cmd_addr), 64'(curAddr));
          checkOutput("s_cmd_wdata", 64'(sIcb.cmd_wdata), 64'(curWdata));
          checkOutput("s_cmd_wmask", 64'(sIcb.cmd_wmask), 64'(curMask));
          checkOutput("s_cmd_read",  64'(sIcb.cmd_read), 64'(curRead));
        end
        e.tgt = tgt;
        e.rd  = curRead;
        r = (tgt == 4) ? {1'b1, 32'h0} : slaveResp(tgt, curAddr);
        e.err   = r[32];
        e.rdata = r[31:0];
        expQ.push_back(e);
        cmdPending = 0;
        cmdWait = 0;
      end else begin
        cmdWait++;
        if (cmdWait > 300) begin
          checks++;
          errors++;
          $display("[TB] FAIL cmd_timeout: got no accept in %0d cycles, expected accept", cmdWait);
          abort = 1;
        end
      end
    end

    for (int n = 0; n < 4; n++) begin
      if (sIcb.rsp_valid[n] && sIcb.rsp_ready[n]) begin
        slvRd[n] = (slvRd[n] + 1) % 8;
        slvCnt[n]--;
        slvPresent[n] = 0;
      end
      if (sIcb.cmd_valid[n] && sIcb.cmd_ready[n]) begin
        slvMem[n][slvWr[n]] = slaveResp(n, sIcb.cmd_addr);
        slvWr[n] = (slvWr[n] + 1) % 8;
        slvCnt[n]++;
      end
    end
  endtask

  task automatic applyStimulus(input bit noNew);
    int r;
    logic [3:0] rgn;
    if (!cmdPending && !noNew && $urandom_range(0, 3) != 0) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1) rgn = lastRgn;
      else rgn = (r < 8) ? 4'(r % 4 + 1) : ((r == 8) ? 4'h9 : 4'h0);
      lastRgn    = rgn;
      curAddr    = {rgn, 28'($urandom)};
      curWdata   = $urandom;
      curMask    = 4'($urandom);
      curRead    = 1'($urandom);
      cmdPending = 1;
    end
    mIcb.cmd_valid = cmdPending;
    mIcb.cmd_addr  = curAddr;
    mIcb.cmd_read  = curRead;
    mIcb.cmd_wdata = curWdata;
    mIcb.cmd_wmask = curMask;
    mIcb.rsp_ready = noNew ? 1'b1 : ($urandom_range(0, 3) != 0);
    for (int n = 0; n < 4; n++) begin
      sIcb.cmd_ready[n] = ($urandom_range(0, 2) != 0);
      if (!slvPresent[n] && slvCnt[n] > 0 && $urandom_range(0, 1) == 1) slvPresent[n] = 1;
      if (slvPresent[n]) {sIcb.rsp_err[n], sIcb.rsp_rdata[32*n +: 32]} = slvMem[n][slvRd[n]];
      else {sIcb.rsp_err[n], sIcb.rsp_rdata[32*n +: 32]} = {1'($urandom), 32'($urandom)};
      sIcb.rsp_valid[n] = slvPresent[n];
    end
  endtask

  // Scoreboard monitor: every master response handshake pops and compares the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && !abort && mIcb.rsp_valid[0] && mIcb.rsp_ready[0]) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rsp_unexpected: got response, expected none");
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_err", 64'(mIcb.rsp_err), 64'(e.err));
        if (e.tgt == 4 || e.rd) checkOutput("rsp_rdata", 64'(mIcb.rsp_rdata), 64'(e.rdata));
      end
    end
  end

  initial begin
    bit didReset = 0;
    clearModels();
    mIcb.rsp_ready = 1'b0;
    sIcb.cmd_ready = 4'h0;
    sIcb.rsp_err   = 4'h0;
    sIcb.rsp_rdata = '0;
    mIcb.cmd_valid = 1'b1;
    mIcb.cmd_addr  = 32'h1000_0010;
    mIcb.cmd_read  = 1'b1;
    mIcb.cmd_wdata = 32'hFFFF_FFFF;
    mIcb.cmd_wmask = 4'hF;
    sIcb.cmd_ready = 4'hF;
    #1 checkResetOutputs("reset_init");
    clearModels();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int cyc = 0; cyc < 3000 && !abort; cyc++) begin
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
      if (!didReset && cyc >= 1500 && (expQ.size() == OT || cyc >= 2000)) begin
        pulseReset("reset_mid");
        didReset = 1;
      end else begin
        applyStimulus(cyc >= 2700);
      end
    end

    checkOutput("drain_empty", 64'(expQ.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icb_split4.md
Name: icb_split4

Overview:
- 1-master-to-4-slave ICB splitter placed directly downstream of the core's ICB master port (core_icb_*).
- Decodes each command's address region and forwards the command to one of four peripheral/memory slaves.
- Routes each response back to the core in command order.
- Commands to unmapped regions complete through an internal error slave, so the core never hangs.

Parameters:
- S0_REGION, 4'h1, value of addr[31:28] decoded to slave 0
- S1_REGION, 4'h2, value of addr[31:28] decoded to slave 1
- S2_REGION, 4'h3, value of addr[31:28] decoded to slave 2
- S3_REGION, 4'h4, value of addr[31:28] decoded to slave 3
- OT_DEPTH, 2, maximum outstanding commands (power of 2, ≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_icb_cmd_valid  in  1  master command valid
- m_icb_cmd_ready  out  1  master command ready
- m_icb_cmd_addr  in  32  command address
- m_icb_cmd_read  in  1  1=read, 0=write
- m_icb_cmd_wdata  in  32  write data
- m_icb_cmd_wmask  in  4  byte write strobes
- m_icb_rsp_valid  out  1  response valid
- m_icb_rsp_ready  in  1  response ready
- m_icb_rsp_err  out  1  response error
- m_icb_rsp_rdata  out  32  read data
- s_icb_cmd_valid  out  4  per-slave command valid (bit n = slave n)
- s_icb_cmd_ready  in  4  per-slave command ready
- s_icb_cmd_addr  out  32  broadcast address
- s_icb_cmd_read  out  1  broadcast read flag
- s_icb_cmd_wdata  out  32  broadcast write data
- s_icb_cmd_wmask  out  4  broadcast strobes
- s_icb_rsp_valid  in  4  per-slave response valid
- s_icb_rsp_ready  out  4  per-slave response ready
- s_icb_rsp_err  in  4  per-slave response error
- s_icb_rsp_rdata  in  128  slave n read data at [32n+31:32n]

Behaviour:
- Reset: all outputs 0. ID FIFO empty, count=0, error-slave response idle.
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Decode (combinational): tgt = n if addr[31:28]==Sn_REGION. Otherwise tgt = 4 (error slave). If regions overlap, the lowest n wins.
- Ordering FIFO:
  - OT_DEPTH entries of 3-bit tgt, plus a count.
  - Push on master cmd handshake. Pop on master rsp handshake.
  - Pointers wrap modulo OT_DEPTH.
  - Simultaneous push and pop: count unchanged.
- Command gate: block = (count==OT_DEPTH) OR (count!=0 AND tgt!=tgt of most recently pushed entry). Mixing targets only after drain keeps responses in order without reordering hardware.
- Forwarding:
  - s_icb_cmd_valid[tgt] = m_icb_cmd_valid & ~block.
  - m_icb_cmd_ready = ~block & (tgt==4 ? err_free : s_icb_cmd_ready[tgt]).
  - Both are zero-latency combinational paths.
  - The ready path must not depend on m_icb_rsp_ready.
- Error slave:
  - err_free = no pending error response.
  - On an accepted cmd with tgt==4, err_rsp_valid rises the next cycle with err=1, rdata=0.
  - It holds until the master rsp handshake.
- Response routing:
  - head = FIFO head.
  - m_icb_rsp_* = selected from slave[head], or the error slave when head==4.
  - s_icb_rsp_ready[head] = m_icb_rsp_ready & (count!=0); all other bits 0.
  - Slave responses with count==0 or from a non-head slave are not acknowledged; they stay stalled, and a protocol assertion fires in simulation.
- Writes produce responses exactly like reads (rdata don't-care, err passed through).
- Reset mid-transaction: FIFO and error slave clear immediately. In-flight slave responses are abandoned, and slaves are reset by the same rst_n.
- No combinational loop from s_icb_rsp_valid to s_icb_cmd_valid.

Test Plan:
- Read to 0x1000_0010, slave0 ready=1, rsp one cycle later with rdata 0xDEADBEEF -> s_icb_cmd_valid=4'b0001; m rdata 0xDEADBEEF, err=0; count returns to 0.
- Back-to-back writes to 0x2000_0000 and 0x2000_0004, slave1 rsp delayed 3 cycles -> both accepted (count=2). Third cmd stalls (m_icb_cmd_ready=0) until the first rsp pops.
- Read 0x2000_0000 outstanding, then cmd to 0x3000_0000 -> cmd_ready=0 until slave1 rsp handshakes, then slave2 receives the cmd.
- Read 0x9000_0000 (unmapped) -> accepted in 1 cycle; next cycle rsp_valid=1, err=1, rdata=0; no s_icb_cmd_valid bit asserted.
- Slave3 returns err=1 with m_icb_rsp_ready held 0 for 4 cycles -> rsp_valid/err stay stable; s_icb_rsp_ready[3]=0 until the master is ready.
- rst_n pulsed low with count=2 -> all outputs 0 asynchronously; after release the FIFO is empty and a new cmd is accepted normally.
